// File: rtl/pc_unit.sv
// Fetch-address generator for the IF stage. It produces the sequential PC and
// handles stall, redirect, trap entry, halt/resume and misaligned-target trapping.
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int              INC          = 4,
  parameter int              ALIGN_BITS   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus_inc,
  output logic            pc_valid,
  output logic [XLEN-1:0] epc_out,
  output logic            misalign_err
);

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);
  localparam logic [XLEN-1:0] INC_X      = XLEN'(INC);

  state_t state;
  logic   misaligned;

  assign misaligned  = (redirect_target & ALIGN_MASK) != '0;
  assign pc_plus_inc = pc_out + INC_X;

  // NOTE: all state here uses non-blocking assignments so every branch sees the
  // pre-edge pc_out; epc_out <= pc_out therefore captures the faulting PC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= BOOT;
      pc_out       <= RESET_VECTOR;
      pc_valid     <= 1'b0;
      epc_out      <= '0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      case (state)
        BOOT: begin
          state    <= RUN;
          pc_valid <= 1'b1;
        end
        RUN: begin
          if (trap) begin
            pc_out  <= TRAP_VECTOR;
            epc_out <= pc_out;
          end else if (redirect_valid && misaligned) begin
            misalign_err <= 1'b1;
            pc_out       <= TRAP_VECTOR;
            epc_out      <= pc_out;
          end else if (redirect_valid) begin
            pc_out <= redirect_target;
          end else if (halt_req) begin
            state    <= HALT;
            pc_valid <= 1'b0;
          end else if (!stall) begin
            pc_out <= pc_plus_inc;
          end
        end
        HALT: begin
          if (trap) begin
            state    <= RUN;
            pc_valid <= 1'b1;
            pc_out   <= TRAP_VECTOR;
            epc_out  <= pc_out;
          end else if (resume) begin
            state    <= RUN;
            pc_valid <= 1'b1;
          end
        end
        default: begin
          // Unused encoding: recover through BOOT rather than lock up.
          state    <= BOOT;
          pc_out   <= RESET_VECTOR;
          pc_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a driver issues directed then random stimulus and
// queues model predictions; a monitor pops and compares them after each edge.
module tb_pc_unit;

  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        trap = 1'b0;
  logic        halt_req = 1'b0;
  logic        resume = 1'b0;
  logic [31:0] pc_out;
  logic [31:0] pc_plus_inc;
  logic        pc_valid;
  logic [31:0] epc_out;
  logic        misalign_err;

  pc_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap            (trap),
    .halt_req        (halt_req),
    .resume          (resume),
    .pc_out          (pc_out),
    .pc_plus_inc     (pc_plus_inc),
    .pc_valid        (pc_valid),
    .epc_out         (epc_out),
    .misalign_err    (misalign_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] epc;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: mode and architectural values, updated from the rules.
  typedef enum {M_BOOT, M_RUN, M_HALT} mode_t;
  mode_t       m_mode = M_BOOT;
  logic [31:0] m_pc = '0;
  logic        m_valid = 1'b0;
  logic [31:0] m_epc = '0;
  logic        m_mis = 1'b0;

  function automatic logic [31:0] add4(input logic [31:0] a);
    longint unsigned s;
    s = (longint'(a) + 4) % 64'h1_0000_0000;
    return 32'(s);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_BOOT; m_pc = '0; m_valid = 1'b0; m_epc = '0; m_mis = 1'b0;
  endtask

  task automatic model_edge(input logic st, input logic rv, input logic [31:0] tgt,
                            input logic tr, input logic hr, input logic rs, input string tag);
    exp_t e;
    m_mis = 1'b0;
    case (m_mode)
      M_BOOT: begin m_mode = M_RUN; m_valid = 1'b1; end
      M_RUN: begin
        if (tr) begin m_epc = m_pc; m_pc = TV; end
        else if (rv && (tgt % 4) != 0) begin m_mis = 1'b1; m_epc = m_pc; m_pc = TV; end
        else if (rv) m_pc = tgt;
        else if (hr) begin m_mode = M_HALT; m_valid = 1'b0; end
        else if (!st) m_pc = add4(m_pc);
      end
      default: begin
        if (tr) begin m_mode = M_RUN; m_valid = 1'b1; m_epc = m_pc; m_pc = TV; end
        else if (rs) begin m_mode = M_RUN; m_valid = 1'b1; end
      end
    endcase
    e.tag = tag; e.pc = m_pc; e.valid = m_valid; e.epc = m_epc; e.mis = m_mis;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic st, input logic rv, input logic [31:0] tgt,
                      input logic tr, input logic hr, input logic rs, input string tag);
    @(negedge clk);
    stall = st; redirect_valid = rv; redirect_target = tgt;
    trap = tr; halt_req = hr; resume = rs;
    model_edge(st, rv, tgt, tr, hr, rs, tag);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic jump(input logic [31:0] tgt, input string tag);
    step(1'b0, 1'b1, tgt, 1'b0, 1'b0, 1'b0, tag);
  endtask

  // Direct spot check of a spec-given value, taken just after the pending edge.
  task automatic expect_now(input string name, input logic [31:0] pc, input logic valid);
    @(posedge clk);
    #2;
    check({name, "_pc"}, pc_out, pc);
    check({name, "_valid"}, 32'(pc_valid), 32'(valid));
  endtask

  // Monitor: compares every queued prediction one edge after it was issued.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.tag, ".pc_out"}, pc_out, e.pc);
        check({e.tag, ".pc_plus_inc"}, pc_plus_inc, add4(e.pc));
        check({e.tag, ".pc_valid"}, 32'(pc_valid), 32'(e.valid));
        check({e.tag, ".epc_out"}, epc_out, e.epc);
        check({e.tag, ".misalign_err"}, 32'(misalign_err), 32'(e.mis));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] tgt;
    // Reset/boot
    repeat (3) @(posedge clk);
    #1;
    check("reset_pc", pc_out, 32'h0);
    check("reset_valid", 32'(pc_valid), 32'h0);
    check("reset_epc", epc_out, 32'h0);
    #2 reset = 1'b1;
    #1;
    check("boot_valid_before_edge", 32'(pc_valid), 32'h0);
    model_reset();
    idle("boot");   expect_now("boot_edge", 32'h0, 1'b1);
    idle("seq4");   expect_now("seq4", 32'h4, 1'b1);
    idle("seq8");
    idle("seqC");   expect_now("seqC", 32'hC, 1'b1);

    // Stall vs redirect
    jump(32'h10, "to10");
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "stall1");
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "stall2");
    expect_now("stall_hold", 32'h10, 1'b1);
    step(1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0, "stall_redirect");
    expect_now("stall_redirect", 32'h80, 1'b1);
    idle("after80");
    expect_now("after80", 32'h84, 1'b1);

    // Misaligned redirect
    jump(32'h20, "to20");
    jump(32'h42, "misalign");
    @(posedge clk);
    #2;
    check("misalign_pc", pc_out, TV);
    check("misalign_flag", 32'(misalign_err), 32'h1);
    check("misalign_epc", epc_out, 32'h20);
    idle("misalign_clear");
    expect_now("misalign_next", 32'h104, 1'b1);
    check("misalign_pulse_gone", 32'(misalign_err), 32'h0);

    // Trap priority over redirect and halt
    jump(32'h30, "to30");
    step(1'b0, 1'b1, 32'h200, 1'b1, 1'b1, 1'b0, "trap_prio");
    expect_now("trap_prio", TV, 1'b1);
    check("trap_epc", epc_out, 32'h30);
    idle("trap_run");
    expect_now("trap_run", 32'h104, 1'b1);

    // Halt / resume
    jump(32'h40, "to40");
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, "halt");
    for (int i = 0; i < 5; i++)
      step(i[0], 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, "halted");
    expect_now("halt_hold", 32'h40, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, "resume");
    expect_now("resume", 32'h40, 1'b1);
    idle("after_resume");
    expect_now("after_resume", 32'h44, 1'b1);

    // Wrap and asynchronous reset
    jump(32'hFFFF_FFFC, "to_top");
    idle("wrap");
    expect_now("wrap", 32'h0, 1'b1);
    idle("post_wrap");
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_reset_pc", pc_out, 32'h0);
    check("async_reset_valid", 32'(pc_valid), 32'h0);
    check("async_reset_epc", epc_out, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    idle("reboot");

    // Randomised run
    for (int i = 0; i < 400; i++) begin
      tgt = $urandom();
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      step($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 20, tgt,
           $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 8,
           $urandom_range(0, 99) < 30, "rand");
    end

    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised successor to the plain program counter register; this is the fetch-address generator for the 5-stage pipeline's IF stage.
- Generates the sequential PC and accepts stall, branch/jump redirect, trap entry and halt/resume.
- Flags misaligned redirect targets and captures the exception PC.
- Feeds instruction memory address and the IF/ID pipeline register.

Parameters:
- XLEN, 32, PC width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value held during and after reset (XLEN bits).
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap or misaligned redirect (XLEN bits).
- INC, 4, sequential increment in bytes.
- ALIGN_BITS, 2, number of low target bits that must be zero for a legal redirect.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- stall  input  1  hold PC (hazard unit).
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_target  input  XLEN  branch/jump destination.
- trap  input  1  exception/interrupt request.
- halt_req  input  1  request to stop fetching.
- resume  input  1  leave HALT.
- pc_out  output  XLEN  current fetch address.
- pc_plus_inc  output  XLEN  pc_out + INC, combinational, wraps modulo 2^XLEN.
- pc_valid  output  1  pc_out is a valid fetch address.
- epc_out  output  XLEN  PC captured at last trap or misaligned redirect.
- misalign_err  output  1  one-cycle pulse, registered.

Behaviour:
- Reset (reset=0, asynchronous, no clock needed):
  - pc_out=RESET_VECTOR, pc_valid=0, epc_out=0, misalign_err=0, state=BOOT.
  - Mid-operation reset forces these values immediately and discards any pending redirect or trap.
- States: BOOT, RUN, HALT. All transitions are registered.
- BOOT: on the first rising edge with reset=1 → RUN, pc_valid=1, pc_out stays RESET_VECTOR. All other inputs are ignored in BOOT.
- RUN: per-edge priority, highest first:
  1. trap=1: pc_out←TRAP_VECTOR, epc_out←pc_out.
  2. redirect_valid=1 and redirect_target[ALIGN_BITS-1:0]≠0: misalign_err←1, pc_out←TRAP_VECTOR, epc_out←pc_out.
  3. redirect_valid=1 and target aligned: pc_out←redirect_target. A redirect overrides stall.
  4. halt_req=1: state←HALT, pc_valid←0, pc_out held.
  5. stall=1: pc_out held.
  6. Otherwise: pc_out←pc_out+INC, truncated to XLEN bits (0xFFFF_FFFC+4 → 0x0000_0000, no flag).
- misalign_err is 1 for exactly the cycle after a misaligned redirect; otherwise 0.
- halt_req arriving together with trap or redirect is ignored. The requester must hold it.
- HALT:
  - pc_out held and pc_valid=0.
  - redirect_valid and stall are ignored.
  - trap=1: state←RUN, pc_valid←1, pc_out←TRAP_VECTOR, epc_out←pc_out.
  - resume=1 (no trap): state←RUN, pc_valid←1, pc_out unchanged.
  - trap and resume together: the trap path wins.
- Latency: every update appears on pc_out one clock after the input is sampled. pc_plus_inc follows pc_out combinationally.
- No illegal-state lockup: an unused state encoding returns to BOOT.

Test Plan:
- Reset/boot: hold reset=0 for 3 cycles, release → pc_out=0x0, pc_valid=0 until the first edge, then pc_valid=1. On later edges pc_out reads 0x0, 0x4, 0x8, 0xC.
- Stall vs redirect: at pc=0x10, stall=1 for 2 cycles → pc stays 0x10. Then stall=1 with redirect_valid=1, target=0x80 → next pc=0x80, then 0x84 once stall=0.
- Misaligned redirect: at pc=0x20, redirect target=0x42 → next cycle pc=0x100, misalign_err=1 for one cycle, epc_out=0x20.
- Trap priority: at pc=0x30, assert trap=1, redirect_valid=1 (target 0x200) and halt_req=1 together → pc=0x100, epc_out=0x30, state RUN.
- Halt/resume: at pc=0x40, pulse halt_req → pc_valid=0 and pc=0x40 held for 5 cycles, redirect ignored. Pulse resume → pc_valid=1, pc=0x40, then 0x44.
- Wrap and async reset: force a run to pc=0xFFFF_FFFC → next pc=0x0. Drop reset between clock edges → pc_out=0x0 and pc_valid=0 immediately, before the next edge.
